// File: rtl/ra_stack_pkg.sv
// ra_stack_pkg: shared defaults and {jal, jr_ra} op encoding for the return-address stack
package ra_stack_pkg;
    localparam int RA_WIDTH = 32;
    localparam int RA_DEPTH = 8;
    localparam logic [1:0] OP_IDLE    = 2'b00;
    localparam logic [1:0] OP_POP     = 2'b01;
    localparam logic [1:0] OP_PUSH    = 2'b10;
    localparam logic [1:0] OP_REPLACE = 2'b11;
endpackage

// File: rtl/ra_stack_ptr.sv
// ra_stack_ptr: stack pointer, occupancy count and sticky overflow/underflow tracking
module ra_stack_ptr import ra_stack_pkg::*; #(
    parameter int DEPTH = RA_DEPTH,
    parameter int CNT_W = $clog2(DEPTH + 1),
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       op,
    input  logic             flush,
    output logic             we,
    output logic [PTR_W-1:0] wr_addr,
    output logic [PTR_W-1:0] tos,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);
    logic [PTR_W-1:0] sp, sp_n;
    logic [CNT_W-1:0] count_n;
    logic             ovf_n, unf_n;
    assign tos   = sp - 1'b1;
    assign empty = count == '0;
    assign full  = count == CNT_W'(DEPTH);
    // A replace on an empty stack degenerates into a plain push.
    always_comb begin
        sp_n    = sp;
        count_n = count;
        ovf_n   = overflow;
        unf_n   = underflow;
        we      = 1'b0;
        wr_addr = sp;
        if (flush) begin
            count_n = '0;
            ovf_n   = 1'b0;
            unf_n   = 1'b0;
        end else if (op == OP_PUSH || (op == OP_REPLACE && empty)) begin
            we      = 1'b1;
            sp_n    = sp + 1'b1;
            count_n = full ? count : count + 1'b1;
            ovf_n   = overflow | full;
        end else if (op == OP_REPLACE) begin
            we      = 1'b1;
            wr_addr = tos;
        end else if (op == OP_POP) begin
            unf_n   = underflow | empty;
            sp_n    = empty ? sp : tos;
            count_n = empty ? count : count - 1'b1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp        <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            sp        <= sp_n;
            count     <= count_n;
            overflow  <= ovf_n;
            underflow <= unf_n;
        end
    end
endmodule

// File: rtl/ra_stack.sv
// ra_stack: circular-buffer return-address stack with flush and overflow/underflow reporting
module ra_stack import ra_stack_pkg::*; #(
    parameter int WIDTH = RA_WIDTH,
    parameter int DEPTH = RA_DEPTH,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             jal,
    input  logic [WIDTH-1:0] ra_in,
    input  logic             jr_ra,
    input  logic             flush,
    output logic [WIDTH-1:0] ra_out,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);
    localparam int PTR_W = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic             we;
    logic [PTR_W-1:0] wr_addr, tos;
    ra_stack_ptr #(.DEPTH(DEPTH), .CNT_W(CNT_W), .PTR_W(PTR_W)) u_ptr (
        .clk       (clk),
        .rst_n     (rst_n),
        .op        ({jal, jr_ra}),
        .flush     (flush),
        .we        (we),
        .wr_addr   (wr_addr),
        .tos       (tos),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );
    // Contents need no reset: the count alone decides what is visible.
    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= ra_in;
    end
    assign ra_out = empty ? '0 : mem[tos];
endmodule

// File: tb/tb_ra_stack.sv
// tb_ra_stack: directed self-checking bench for ra_stack
module tb_ra_stack;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        jal = 1'b0;
    logic        jr_ra = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] ra_in = '0;
    logic [31:0] ra_out;
    logic [3:0]  count;
    logic        empty, full, overflow, underflow;
    int          passed = 0;
    int          total = 0;
    logic [39:0] st;
    logic [39:0] exp_st;

    ra_stack dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .jal       (jal),
        .ra_in     (ra_in),
        .jr_ra     (jr_ra),
        .flush     (flush),
        .ra_out    (ra_out),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;
    assign st = {ra_out, count, empty, full, overflow, underflow};

    task automatic step(input logic j, input logic r, input logic [31:0] d, input logic f);
        jal = j;
        jr_ra = r;
        ra_in = d;
        flush = f;
        @(posedge clk);
        #1;
        jal = 1'b0;
        jr_ra = 1'b0;
        flush = 1'b0;
    endtask

    task automatic test_reset;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        exp_st = {32'h0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        total++;
        if (st !== exp_st) $display("FAIL reset_idle got=%h exp=%h", st, exp_st); else passed++;
    endtask

    task automatic test_push_pop;
        for (int i = 1; i <= 3; i++) begin
            step(1, 0, 32'(i * 'h10), 0);
            exp_st = {32'(i * 'h10), 4'(i), 1'b0, 1'b0, 1'b0, 1'b0};
            total++;
            if (st !== exp_st) $display("FAIL push_%0d got=%h exp=%h", i, st, exp_st); else passed++;
        end
        for (int i = 2; i >= 0; i--) begin
            step(0, 1, 0, 0);
            exp_st = {32'(i * 'h10), 4'(i), i == 0, 1'b0, 1'b0, 1'b0};
            total++;
            if (st !== exp_st) $display("FAIL pop_to_%0d got=%h exp=%h", i, st, exp_st); else passed++;
        end
    endtask

    task automatic test_overflow;
        for (int i = 1; i <= 9; i++) step(1, 0, 32'(i * 'h100), 0);
        for (int k = 0; k < 8; k++) begin
            exp_st = {32'((9 - k) * 'h100), 4'(8 - k), 1'b0, k == 0, 1'b1, 1'b0};
            total++;
            if (st !== exp_st) $display("FAIL ovf_pop_%0d got=%h exp=%h", k, st, exp_st); else passed++;
            step(0, 1, 0, 0);
        end
        exp_st = {32'h0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0};
        total++;
        if (st !== exp_st) $display("FAIL ovf_drained got=%h exp=%h", st, exp_st); else passed++;
        step(0, 0, 0, 1);
        exp_st = {32'h0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        total++;
        if (st !== exp_st) $display("FAIL ovf_flush got=%h exp=%h", st, exp_st); else passed++;
    endtask

    task automatic test_underflow;
        step(0, 1, 0, 0);
        exp_st = {32'h0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        total++;
        if (st !== exp_st) $display("FAIL unf_pop got=%h exp=%h", st, exp_st); else passed++;
        step(1, 0, 32'h44, 0);
        exp_st = {32'h44, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1};
        total++;
        if (st !== exp_st) $display("FAIL unf_push got=%h exp=%h", st, exp_st); else passed++;
        step(1, 0, 32'h55, 1);
        exp_st = {32'h0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        total++;
        if (st !== exp_st) $display("FAIL unf_flush got=%h exp=%h", st, exp_st); else passed++;
    endtask

    task automatic test_replace;
        step(1, 0, 32'hA0, 0);
        step(1, 1, 32'hB0, 0);
        exp_st = {32'hB0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        total++;
        if (st !== exp_st) $display("FAIL repl_top got=%h exp=%h", st, exp_st); else passed++;
        step(0, 1, 0, 0);
        exp_st = {32'h0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        total++;
        if (st !== exp_st) $display("FAIL repl_pop got=%h exp=%h", st, exp_st); else passed++;
        step(1, 1, 32'hC0, 0);
        exp_st = {32'hC0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        total++;
        if (st !== exp_st) $display("FAIL repl_empty got=%h exp=%h", st, exp_st); else passed++;
        step(1, 0, 32'hD0, 0);
        step(0, 1, 0, 0);
        exp_st = {32'hC0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        total++;
        if (st !== exp_st) $display("FAIL repl_order got=%h exp=%h", st, exp_st); else passed++;
        step(0, 0, 0, 1);
    endtask

    task automatic test_async_reset;
        step(1, 0, 32'h5, 0);
        step(1, 0, 32'h6, 0);
        exp_st = {32'h6, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0};
        total++;
        if (st !== exp_st) $display("FAIL rst_pre got=%h exp=%h", st, exp_st); else passed++;
        #2 rst_n = 1'b0;
        #1;
        exp_st = {32'h0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        total++;
        if (st !== exp_st) $display("FAIL rst_async got=%h exp=%h", st, exp_st); else passed++;
        jal = 1'b1;
        ra_in = 32'h99;
        @(posedge clk);
        #1;
        total++;
        if (st !== exp_st) $display("FAIL rst_held got=%h exp=%h", st, exp_st); else passed++;
        jal = 1'b0;
        #2 rst_n = 1'b1;
        step(0, 1, 0, 0);
        exp_st = {32'h0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        total++;
        if (st !== exp_st) $display("FAIL rst_after got=%h exp=%h", st, exp_st); else passed++;
        step(1, 0, 32'h77, 0);
        exp_st = {32'h77, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1};
        total++;
        if (st !== exp_st) $display("FAIL rst_push got=%h exp=%h", st, exp_st); else passed++;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        test_reset();
        test_push_pop();
        test_overflow();
        test_underflow();
        test_replace();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
